// File: rtl/alu_pkg.sv
// Shared types for the ALU decode stage: ALU operation codes, cmd field
// encodings, stage FSM states and the decoded control bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_ADC = 3'd4,
    ALU_SBC = 3'd5,
    ALU_EOR = 3'd6,
    ALU_MUL = 3'd7
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_MUL_WAIT = 2'd2
  } stage_state_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_SBC = 4'b0110;
  localparam logic [3:0] CMD_RSC = 4'b0111;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_BIC = 4'b1110;
  localparam logic [3:0] CMD_MVN = 4'b1111;
  localparam logic [3:0] CMD_MUL = 4'b0000;
  localparam logic [3:0] CMD_MLA = 4'b0001;

  typedef struct packed {
    alu_ctl_e   alu_ctl;
    logic       no_write;
    logic       shift;
    logic       swap;
    logic       inv;
    logic       illegal;
    logic [1:0] flag_w;
  } decode_t;

  // Arithmetic operations produce carry/overflow, so only they may write CV.
  function automatic logic writes_cv(input alu_ctl_e ctl);
    return (ctl == ALU_ADD) || (ctl == ALU_SUB) || (ctl == ALU_ADC) || (ctl == ALU_SBC);
  endfunction

endpackage

// File: rtl/alu_decode_core.sv
// Purely combinational instruction-to-ALU-control decode table.
module alu_decode_core
  import alu_pkg::*;
(
  input  logic       alu_op,
  input  logic       s,
  input  logic       branch,
  input  logic       mul,
  input  logic [3:0] cmd,
  output decode_t    dec
);

  // Multiply wins over data-processing; only MUL/MLA are legal multiply cmds.
  always_comb begin
    dec = '0;
    dec.alu_ctl = ALU_ADD;
    if (mul) begin
      if (alu_op && (cmd != CMD_MUL) && (cmd != CMD_MLA)) begin
        dec.illegal = 1'b1;
      end else begin
        dec.alu_ctl = ALU_MUL;
        dec.flag_w  = {s, 1'b0};
      end
    end else if (alu_op) begin
      case (cmd)
        CMD_ADD: dec.alu_ctl = ALU_ADD;
        CMD_SUB: dec.alu_ctl = ALU_SUB;
        CMD_AND: dec.alu_ctl = ALU_AND;
        CMD_ORR: dec.alu_ctl = ALU_ORR;
        CMD_EOR: dec.alu_ctl = ALU_EOR;
        CMD_ADC: dec.alu_ctl = ALU_ADC;
        CMD_SBC: dec.alu_ctl = ALU_SBC;
        CMD_RSB: begin dec.alu_ctl = ALU_SUB; dec.swap = 1'b1; end
        CMD_RSC: begin dec.alu_ctl = ALU_SBC; dec.swap = 1'b1; end
        CMD_BIC: begin dec.alu_ctl = ALU_AND; dec.inv = 1'b1; end
        CMD_CMP: begin dec.alu_ctl = ALU_SUB; dec.no_write = 1'b1; end
        CMD_CMN: begin dec.alu_ctl = ALU_ADD; dec.no_write = 1'b1; end
        CMD_TST: begin dec.alu_ctl = ALU_AND; dec.no_write = 1'b1; end
        CMD_TEQ: begin dec.alu_ctl = ALU_EOR; dec.no_write = 1'b1; end
        CMD_MVN: begin dec.alu_ctl = ALU_ADD; dec.shift = 1'b1; dec.inv = 1'b1; end
        CMD_MOV: begin dec.alu_ctl = ALU_ADD; dec.shift = 1'b1; end
        default: dec.alu_ctl = ALU_ADD;
      endcase
      dec.flag_w = {s, s && writes_cv(dec.alu_ctl)};
    end else begin
      // Address generation: branches add, loads/stores follow the U bit in cmd[2].
      dec.alu_ctl = (branch || cmd[2]) ? ALU_ADD : ALU_SUB;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage with valid/ready handshake and a fixed-latency
// multiply wait sequence in front of the output register.
module alu_decode_stage #(
  parameter int MUL_LATENCY = 4,
  parameter int CTL_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             alu_op,
  input  logic             s,
  input  logic             branch,
  input  logic             mul,
  input  logic [3:0]       cmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTL_W-1:0] alu_ctl,
  output logic             no_write,
  output logic             shift,
  output logic             swap,
  output logic             inv,
  output logic             illegal,
  output logic [1:0]       flag_w,
  output logic             mul_busy,
  output logic             mul_done
);
  import alu_pkg::*;

  localparam int CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int CNT_LOAD = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
  localparam bit MUL_MULTI_CYCLE = (MUL_LATENCY > 1);

  stage_state_e     state;
  logic [CNT_W-1:0] cnt;
  decode_t          dec;
  decode_t          pend;
  decode_t          res;
  logic             accept;

  alu_decode_core u_core (
    .alu_op (alu_op),
    .s      (s),
    .branch (branch),
    .mul    (mul),
    .cmd    (cmd),
    .dec    (dec)
  );

  assign in_ready  = !reset && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);
  assign mul_busy  = (state == ST_MUL_WAIT);

  assign alu_ctl  = CTL_W'(res.alu_ctl);
  assign no_write = res.no_write;
  assign shift    = res.shift;
  assign swap     = res.swap;
  assign inv      = res.inv;
  assign illegal  = res.illegal;
  assign flag_w   = res.flag_w;

  // A multiply result is parked in pend so the visible outputs keep their
  // previous value until the result is actually valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pend     <= '0;
      res      <= '0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (mul && MUL_MULTI_CYCLE) begin
              state <= ST_MUL_WAIT;
              cnt   <= CNT_W'(CNT_LOAD);
              pend  <= dec;
            end else begin
              state    <= ST_HOLD;
              res      <= dec;
              mul_done <= mul;
            end
          end else if ((state == ST_HOLD) && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_MUL_WAIT: begin
          if (cnt == '0) begin
            state    <= ST_HOLD;
            res      <= pend;
            mul_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 Parameter MUL_LATENCY, default 4, cycles from MUL acceptance to out_valid; legal range 1..15.
REQ-002 Parameter CTL_W, default 3, alu_ctl width; minimum 3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  decode request present.
REQ-006 in_ready  output  1  stage accepts request this cycle.
REQ-007 alu_op, s, branch, mul  input  1 each  data-processing, set-flags, branch and multiply qualifiers.
REQ-008 cmd  input  4  instruction cmd field.
REQ-009 out_valid  output  1  registered decode result valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 alu_ctl  output  CTL_W  ALU operation select.
REQ-012 no_write, shift, swap, inv, illegal  output  1 each  decode controls.
REQ-013 flag_w  output  2  {NZ write, CV write}.
REQ-014 mul_busy  output  1  multiply sequence in progress; mul_done  output  1  one-cycle pulse when multiply result becomes valid.

Function
REQ-015 Decode with alu_op=1, mul=0, cmd -> {alu_ctl, no_write, shift, swap, inv}: 0100 ADD {0,0,0,0,0}; 0010 SUB {1,0,0,0,0}; 0000 AND {2,0,0,0,0}; 1100 ORR {3,0,0,0,0}; 0001 EOR {6,0,0,0,0}; 0101 ADC {4,0,0,0,0}; 0110 SBC {5,0,0,0,0}; 0011 RSB {1,0,0,1,0}; 0111 RSC {5,0,0,1,0}; 1110 BIC {2,0,0,0,1}; 1010 CMP {1,1,0,0,0}; 1011 CMN {0,1,0,0,0}; 1000 TST {2,1,0,0,0}; 1001 TEQ {6,1,0,0,0}; 1111 MVN {0,0,1,0,1}; 1101 MOV/shifts {0,0,1,0,0}.
REQ-016 flag_w[1] = s; flag_w[0] = s AND alu_ctl in {0,1,4,5}, for alu_op=1, mul=0.
REQ-017 alu_op=0, mul=0: branch=1 -> alu_ctl=0; else cmd[2]=1 -> 0, cmd[2]=0 -> 1; flag_w, no_write, shift, swap, inv all 0.
REQ-018 mul=1 (overrides alu_op): alu_ctl=7, flag_w={s,0}, other controls 0.
REQ-019 illegal=1 only when alu_op=1 and mul=1 and cmd not in {0000, 0001} (MUL, MLA); all other controls then 0, result still delivered.
REQ-020 FSM states IDLE, HOLD, MUL_WAIT; reset state IDLE.
REQ-021 in_ready = (state==IDLE) OR (state==HOLD AND out_ready); in_ready=0 in MUL_WAIT.
REQ-022 Accept = in_valid AND in_ready; non-mul accept -> outputs registered, state HOLD, out_valid=1 next cycle (latency 1).
REQ-023 Mul accept with MUL_LATENCY=1 behaves as REQ-022 plus mul_done pulse with out_valid.
REQ-024 Mul accept with MUL_LATENCY>1 -> MUL_WAIT, counter loaded MUL_LATENCY-2, mul_busy=1, out_valid=0; decrement per cycle; at counter 0 -> HOLD, out_valid=1, mul_done=1 for that cycle only.
REQ-025 HOLD: outputs stable while out_ready=0; out_ready=1 without accept -> IDLE, out_valid=0; out_ready=1 with accept -> back-to-back, new result next cycle.
REQ-026 Decode outputs hold last value when out_valid=0.
REQ-027 Counter width $clog2(MUL_LATENCY); no wrap below 0.

Reset
REQ-028 reset asserted: state IDLE, counter 0, all outputs 0 immediately, independent of clk.
REQ-029 reset during MUL_WAIT or HOLD discards the in-flight result; no out_valid or mul_done afterwards.

Structure
REQ-030 Package alu_pkg holds alu_ctl enum (ADD=0..EOR=6, MUL=7), cmd localparams and state enum.
REQ-031 Combinational table in sub-module alu_decode_core; alu_decode_stage holds FSM, counter and output registers.

Verification
REQ-032 alu_op=1, cmd=0011, s=1, out_ready=1 -> next cycle out_valid=1, alu_ctl=1, swap=1, flag_w=11.
REQ-033 mul=1, s=1, cmd=0000, MUL_LATENCY=4 -> in_ready=0 and mul_busy=1 for 3 cycles, out_valid=1 and mul_done=1 on cycle 4, alu_ctl=7, flag_w=10.
REQ-034 out_ready=0 for 5 cycles after ADD accept -> out_valid and alu_ctl=0 held, in_ready=0; out_ready=1 with TST pending -> TST result next cycle, no_write=1.
REQ-035 alu_op=0, branch=0, cmd=0000 -> alu_ctl=1, flag_w=00; branch=1 -> alu_ctl=0.
REQ-036 reset pulse mid-MUL_WAIT -> all outputs 0 at once; no mul_done in following 10 cycles.
REQ-037 mul=1, cmd=1010 -> illegal=1, out_valid=1, no_write=shift=swap=inv=0.
